wb_burst_initiator: RTL and testbench

//  Wishbone B3 bus master that turns one request into a classic single access or an

---
 rtl/wb_burst_initiator_if.sv | 47 ++++
 rtl/wb_burst_initiator.sv | 135 +++++++++++++
 tb/tb_wb_burst_initiator.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_initiator_if.sv
// Request, data-stream and Wishbone master signals of the burst initiator.
// The master modport is the initiator's view; slave is the engine/responder side.
interface wb_burst_initiator_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  logic          req_valid_i;
  logic          req_ready_o;
  logic [aw-1:0] req_adr_i;
  logic          req_we_i;
  logic [3:0]    req_sel_i;
  logic [1:0]    req_len_i;
  logic          req_wrap_i;
  logic [dw-1:0] wdat_i;
  logic          wdat_valid_i;
  logic          wdat_ready_o;
  logic [dw-1:0] rdat_o;
  logic          rdat_valid_o;
  logic          done_o;
  logic          err_o;
  logic [aw-1:0] wb_adr_o;
  logic [dw-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic [dw-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic          wb_rty_i;

  modport master (
    input  req_valid_i, req_adr_i, req_we_i, req_sel_i, req_len_i, req_wrap_i,
    input  wdat_i, wdat_valid_i, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    output req_ready_o, wdat_ready_o, rdat_o, rdat_valid_o, done_o, err_o,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
  );

  modport slave (
    output req_valid_i, req_adr_i, req_we_i, req_sel_i, req_len_i, req_wrap_i,
    output wdat_i, wdat_valid_i, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    input  req_ready_o, wdat_ready_o, rdat_o, rdat_valid_o, done_o, err_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
  );
endinterface

// File: rtl/wb_burst_initiator.sv
// Wishbone B3 master: one request becomes a classic single access or an
// incrementing linear/wrapped burst of 4, 8 or 16 beats.
module wb_burst_initiator #(
  parameter int dw = 32,
  parameter int aw = 32
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_burst_initiator_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, TERM} state_e;

  state_e        state_q, state_d;
  logic [aw-1:0] adr_q, adr_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [1:0]    len_q, len_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          active;
  logic          stb;
  logic          abort;
  logic          beat_done;
  logic          last_beat;
  logic [aw-1:0] adr_inc;
  logic [aw-1:0] wrap_mask;
  logic          unused_adr_lsb;

  assign unused_adr_lsb = ^bus.req_adr_i[1:0];

  assign active    = (state_q == ACTIVE);
  assign stb       = active & (~we_q | bus.wdat_valid_i);
  // err/rty take priority over a simultaneous ack: the beat is not counted
  assign abort     = stb & (bus.wb_err_i | bus.wb_rty_i);
  assign beat_done = stb & bus.wb_ack_i & ~abort;
  assign last_beat = (cnt_q == 4'd0);
  assign adr_inc   = adr_q + aw'(4);

  always_comb begin
    wrap_mask = '0;
    case (len_q)
      2'b01:   wrap_mask[3:2] = '1;
      2'b10:   wrap_mask[4:2] = '1;
      2'b11:   wrap_mask[5:2] = '1;
      default: wrap_mask = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      len_q   <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    len_d   = len_q;
    wrap_d  = wrap_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          state_d = ACTIVE;
          adr_d   = {bus.req_adr_i[aw-1:2], 2'b00};
          we_d    = bus.req_we_i;
          sel_d   = bus.req_sel_i;
          len_d   = bus.req_len_i;
          wrap_d  = bus.req_wrap_i;
          err_d   = 1'b0;
          case (bus.req_len_i)
            2'b01:   cnt_d = 4'd3;
            2'b10:   cnt_d = 4'd7;
            2'b11:   cnt_d = 4'd15;
            default: cnt_d = 4'd0;
          endcase
        end
      end
      ACTIVE: begin
        if (abort) begin
          state_d = TERM;
          err_d   = 1'b1;
        end else if (beat_done) begin
          if (last_beat) begin
            state_d = TERM;
          end else begin
            cnt_d = cnt_q - 4'd1;
            // wrapped bursts only advance the word index inside the aligned block
            adr_d = wrap_q ? ((adr_q & ~wrap_mask) | (adr_inc & wrap_mask)) : adr_inc;
          end
        end
      end
      TERM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o  = (state_q == IDLE) & ~wb_rst_i;
  assign bus.wdat_ready_o = beat_done & we_q;
  assign bus.rdat_valid_o = beat_done & ~we_q;
  assign bus.rdat_o       = bus.wb_dat_i;
  assign bus.done_o       = (state_q == TERM);
  assign bus.err_o        = (state_q == TERM) & err_q;

  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dw'(bus.wdat_i);
  assign bus.wb_sel_o = sel_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_cyc_o = active;
  assign bus.wb_stb_o = stb;
  assign bus.wb_cti_o = (!active || len_q == 2'b00) ? 3'b000 :
                        (last_beat ? 3'b111 : 3'b010);
  assign bus.wb_bte_o = (active && wrap_q) ? len_q : 2'b00;
endmodule

// File: tb/tb_wb_burst_initiator.sv
// Directed bench for wb_burst_initiator: zero-wait responder RAM, a beat-level
// reference model compared every cycle, plus literal checks of address traces.
module tb_wb_burst_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_burst_initiator_if bus();
  wb_burst_initiator dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:63];
  logic        mem_clear = 1'b1;
  logic        ack_en = 1'b1;
  logic        err_arm = 1'b0;
  logic        rty_arm = 1'b0;
  int          err_beat = 0;
  logic [31:0] wd_base = 32'h0;

  // reference model: phase 0 idle, 1 bus cycle open, 2 completion cycle
  int          phase = 0, beat = 0, ph_n = 0, bt_n = 0;
  logic [31:0] m_base;
  logic        m_we, m_wrap, m_err;
  logic [3:0]  m_sel;
  logic [1:0]  m_len;
  int          beats = 1;
  bit          started = 0;
  int          n_done = 0, n_rd = 0, cyc_no = 0, last_beat_cyc = 0, done_lat = 0;
  int          low_run = 0, last_gap = 0;
  logic        last_err = 1'b0;
  logic [31:0] trace [$];
  logic [31:0] stall_adr [$];
  logic [2:0]  cti_log [$];

  assign bus.wdat_i   = wd_base + 32'(beat);
  assign bus.wb_ack_i = bus.wb_cyc_o & ack_en;
  assign bus.wb_err_i = bus.wb_cyc_o & bus.wb_stb_o & err_arm & (beat == err_beat);
  assign bus.wb_rty_i = bus.wb_cyc_o & bus.wb_stb_o & rty_arm & (beat == err_beat);
  assign bus.wb_dat_i = mem[bus.wb_adr_o[7:2]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i && bus.wb_we_o &&
                 !bus.wb_err_i && !bus.wb_rty_i) begin
      mem[bus.wb_adr_o[7:2]] <= bus.wb_dat_o;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // address of beat k derived from start address, length and wrap mode
  function automatic logic [31:0] exp_addr(int k);
    logic [31:0] blk;
    if (!m_wrap || m_len == 2'b00) return m_base + 32'(4 * k);
    blk = 32'(4 * beats);
    return m_base - (m_base % blk) + ((m_base % blk + 32'(4 * k)) % blk);
  endfunction

  always @(negedge clk) begin
    logic [31:0] ea;
    logic        exp_stb, ok;
    cyc_no++;
    ea = 32'h0; exp_stb = 1'b0; ok = 1'b0;
    if (started) begin
      chk("req_ready", bus.req_ready_o, (phase == 0 && !rst));
      chk("cyc", bus.wb_cyc_o, phase == 1);
      chk("done", bus.done_o, phase == 2);
      chk("err_o", bus.err_o, phase == 2 && m_err);
      if (phase == 1) begin
        ea      = exp_addr(beat);
        exp_stb = !m_we || bus.wdat_valid_i;
        ok      = exp_stb && bus.wb_ack_i && !bus.wb_err_i && !bus.wb_rty_i;
        chk("adr", bus.wb_adr_o, ea);
        chk("cti", bus.wb_cti_o, (m_len == 2'b00) ? 3'd0 : ((beat == beats - 1) ? 3'd7 : 3'd2));
        chk("bte", bus.wb_bte_o, (m_wrap && m_len != 2'b00) ? m_len : 2'd0);
        chk("sel", bus.wb_sel_o, m_sel);
        chk("we", bus.wb_we_o, m_we);
        chk("stb", bus.wb_stb_o, exp_stb);
        chk("rdat_valid", bus.rdat_valid_o, ok && !m_we);
        chk("wdat_ready", bus.wdat_ready_o, ok && m_we);
        if (ok && !m_we) chk("rdat", bus.rdat_o, mem[ea[7:2]]);
        if (ok && m_we) chk("wb_dat", bus.wb_dat_o, wd_base + 32'(beat));
        if (!exp_stb) stall_adr.push_back(bus.wb_adr_o);
        if (ok) cti_log.push_back(bus.wb_cti_o);
      end else begin
        chk("stb_idle", bus.wb_stb_o, 0);
        chk("rdat_valid_idle", bus.rdat_valid_o, 0);
        chk("wdat_ready_idle", bus.wdat_ready_o, 0);
      end
      if (!bus.wb_cyc_o) low_run++;
      else begin
        if (low_run > 0) last_gap = low_run;
        low_run = 0;
      end
    end
    ph_n = phase;
    bt_n = beat;
    if (rst) ph_n = 0;
    else begin
      case (phase)
        0: if (bus.req_valid_i) begin
          m_base = {bus.req_adr_i[31:2], 2'b00};
          m_we   = bus.req_we_i;
          m_sel  = bus.req_sel_i;
          m_len  = bus.req_len_i;
          m_wrap = bus.req_wrap_i;
          beats  = (m_len == 2'b00) ? 1 : (2 << m_len);
          ph_n   = 1;
          bt_n   = 0;
        end
        1: if (exp_stb && (bus.wb_err_i || bus.wb_rty_i)) begin
          ph_n  = 2;
          m_err = 1'b1;
        end else if (ok) begin
          trace.push_back(ea);
          if (!m_we) n_rd++;
          last_beat_cyc = cyc_no;
          if (beat == beats - 1) begin
            ph_n  = 2;
            m_err = 1'b0;
          end else bt_n = beat + 1;
        end
        default: begin
          ph_n     = 0;
          n_done++;
          last_err = m_err;
          done_lat = cyc_no - last_beat_cyc;
          $display("txn %0d adr=%h we=%0d len=%0d wrap=%0d beats_done=%0d err=%0d",
                   n_done, m_base, m_we, m_len, m_wrap, trace.size(), m_err);
        end
      endcase
    end
  end

  always @(posedge clk) begin
    phase <= ph_n;
    beat  <= bt_n;
  end

  task automatic issue(logic [31:0] a, logic w, logic [3:0] s, logic [1:0] l, logic wr);
    int i;
    bus.req_adr_i  = a;
    bus.req_we_i   = w;
    bus.req_sel_i  = s;
    bus.req_len_i  = l;
    bus.req_wrap_i = wr;
    bus.req_valid_i = 1'b1;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) break;
    end
    chk("req_accepted", bus.req_ready_o, 1);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int s;
    s = n_done;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (n_done > s) break;
    end
    chk("done_seen", n_done > s, 1);
  endtask

  task automatic wait_beat(int k);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (beat >= k) break;
    end
    chk("beat_reached", beat >= k, 1);
  endtask

  initial begin
    int rd0, d0;
    bus.req_valid_i = 1'b0; bus.req_adr_i = '0; bus.req_we_i = 1'b0;
    bus.req_sel_i = '0; bus.req_len_i = '0; bus.req_wrap_i = 1'b0;
    bus.wdat_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 started = 1;
    @(posedge clk);
    #1;
    chk("rst_cyc", bus.wb_cyc_o, 0);
    chk("rst_adr", bus.wb_adr_o, 0);
    chk("rst_cti", bus.wb_cti_o, 0);
    chk("rst_bte", bus.wb_bte_o, 0);
    chk("rst_sel", bus.wb_sel_o, 0);
    chk("rst_we", bus.wb_we_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_ready", bus.req_ready_o, 0);
    mem_clear = 1'b0;
    rst = 1'b0;

    // single read
    trace.delete(); rd0 = n_rd;
    issue(32'h100, 1'b0, 4'hF, 2'b00, 1'b0);
    wait_done();
    chk("t1_beats", trace.size(), 1);
    chk("t1_adr", trace[0], 32'h100);
    chk("t1_rd", n_rd - rd0, 1);
    chk("t1_err", last_err, 0);
    chk("t1_done_lat", done_lat, 1);

    // 4-beat linear read
    trace.delete(); cti_log.delete();
    issue(32'h10, 1'b0, 4'hF, 2'b01, 1'b0);
    wait_done();
    chk("t2_adr0", trace[0], 32'h10);
    chk("t2_adr3", trace[3], 32'h1C);
    chk("t2_cti0", cti_log[0], 3'b010);
    chk("t2_cti3", cti_log[3], 3'b111);

    // 8-beat wrapped write, data 1..8
    trace.delete(); wd_base = 32'd1; bus.wdat_valid_i = 1'b1;
    issue(32'h18, 1'b1, 4'hF, 2'b10, 1'b1);
    wait_done();
    chk("t3_adr1", trace[1], 32'h1C);
    chk("t3_adr2", trace[2], 32'h00);
    chk("t3_adr7", trace[7], 32'h14);
    chk("t3_mem6", mem[6], 32'd1);
    chk("t3_mem0", mem[0], 32'd3);
    chk("t3_mem5", mem[5], 32'd8);

    // 4-beat write with a 3-cycle data stall before beat 2
    trace.delete(); stall_adr.delete(); wd_base = 32'h100;
    issue(32'h0, 1'b1, 4'h3, 2'b01, 1'b0);
    wait_beat(1);
    bus.wdat_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.wdat_valid_i = 1'b1;
    wait_done();
    chk("t4_stalls", stall_adr.size(), 3);
    chk("t4_stall_adr", stall_adr[0], 32'h04);
    chk("t4_stall_adr_last", stall_adr[2], 32'h04);
    chk("t4_mem1", mem[1], 32'h101);

    // 16-beat read aborted by err on beat 3
    trace.delete(); rd0 = n_rd; err_arm = 1'b1; err_beat = 2;
    issue(32'h40, 1'b0, 4'hF, 2'b11, 1'b0);
    wait_done();
    err_arm = 1'b0;
    chk("t5_rd", n_rd - rd0, 2);
    chk("t5_err", last_err, 1);
    chk("t5_ready", bus.req_ready_o, 1);

    // 4-beat wrapped write retried on beat 2: no write committed for it
    trace.delete(); rty_arm = 1'b1; err_beat = 1; wd_base = 32'h200;
    issue(32'h24, 1'b1, 4'h3, 2'b01, 1'b1);
    wait_done();
    rty_arm = 1'b0;
    chk("t7_beats", trace.size(), 1);
    chk("t7_err", last_err, 1);
    chk("t7_mem9", mem[9], 32'h200);
    chk("t7_mem10", mem[10], 32'hA000_000A);

    // linear burst crossing the top of the address space, unaligned start
    trace.delete();
    issue(32'hFFFF_FFFA, 1'b0, 4'hF, 2'b01, 1'b0);
    wait_done();
    chk("t8_adr0", trace[0], 32'hFFFF_FFF8);
    chk("t8_adr2", trace[2], 32'h0);

    // 16-beat wrapped read
    trace.delete();
    issue(32'h34, 1'b0, 4'hF, 2'b11, 1'b1);
    wait_done();
    chk("t9_adr3", trace[3], 32'h0);
    chk("t9_adr15", trace[15], 32'h30);

    // reset on beat 2 of an 8-beat burst
    d0 = n_done;
    issue(32'h80, 1'b0, 4'hF, 2'b10, 1'b0);
    wait_beat(2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_cyc", bus.wb_cyc_o, 0);
    chk("t6_stb", bus.wb_stb_o, 0);
    chk("t6_adr", bus.wb_adr_o, 0);
    chk("t6_cti", bus.wb_cti_o, 0);
    chk("t6_sel", bus.wb_sel_o, 0);
    repeat (3) @(posedge clk);
    #1 chk("t6_no_done", n_done - d0, 0);

    // back-to-back requests
    issue(32'h20, 1'b0, 4'hF, 2'b01, 1'b0);
    issue(32'h20, 1'b0, 4'hF, 2'b01, 1'b0);
    wait_done();
    chk("b2b_gap", last_gap, 2);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
